dtw_traceback: RTL and testbench

- Consumer end of the DTW systolic array's path output.
- Captures the per-PE 2-bit path decisions the array emits, tagged with their T/R indices, into a path memory.
- On command, walks backward from cell (t_len-1, r_len-1) to (0,0) and streams out one (t, r, direction) step per handshake.
- Sits between the systolic array and the alignment post-processing logic.

---
 rtl/dtw_traceback_if.sv | 29 ++
 rtl/dtw_traceback.sv | 170 +++++++++++++++++
 tb/tb_dtw_traceback.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_traceback_if.sv
// Bus bundle for dtw_traceback: path-decision write beats from the systolic
// array plus the traceback step stream toward alignment post-processing.
interface dtw_traceback_if #(
  parameter int N_PE  = 6,
  parameter int IDX_W = 5
);
  logic                  wr_valid;
  logic [N_PE-1:0]       wr_mask;
  logic [N_PE*IDX_W-1:0] wr_tindex;
  logic [N_PE*IDX_W-1:0] wr_rindex;
  logic [N_PE*2-1:0]     wr_path;
  logic                  wr_ready;
  logic                  o_valid;
  logic                  o_ready;
  logic [IDX_W-1:0]      o_t;
  logic [IDX_W-1:0]      o_r;
  logic [1:0]            o_dir;
  logic                  o_last;

  modport master (
    output wr_valid, wr_mask, wr_tindex, wr_rindex, wr_path, o_ready,
    input  wr_ready, o_valid, o_t, o_r, o_dir, o_last
  );

  modport slave (
    input  wr_valid, wr_mask, wr_tindex, wr_rindex, wr_path, o_ready,
    output wr_ready, o_valid, o_t, o_r, o_dir, o_last
  );
endinterface

// File: rtl/dtw_traceback.sv
// DTW path memory and backward walker from (t_len-1, r_len-1) to (0,0).
// Optional step counter output o_steps is enabled by DTW_TB_STEPCNT_EN.
module dtw_traceback #(
  parameter int N_PE    = 6,
  parameter int IDX_W   = 5,
  parameter int MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  dtw_traceback_if.slave   bus,
  input  logic             i_start,
  input  logic [IDX_W:0]   i_t_len,
  input  logic [IDX_W:0]   i_r_len,
  output logic             o_busy,
  output logic             o_err
`ifdef DTW_TB_STEPCNT_EN
  ,
  output logic [IDX_W+1:0] o_steps
`endif
);
  localparam int AW = $clog2(MAX_LEN * MAX_LEN);
  localparam logic [IDX_W:0]   LEN_MAX = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W - 1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_mem [MAX_LEN * MAX_LEN];
  logic [IDX_W-1:0] r_cur_t;
  logic [IDX_W-1:0] r_cur_r;
  logic [IDX_W-1:0] r_o_t;
  logic [IDX_W-1:0] r_o_r;
  logic [1:0]       r_o_dir;
  logic             r_o_valid;
  logic             r_o_last;
  logic             r_busy;
  logic             r_err;
`ifdef DTW_TB_STEPCNT_EN
  logic [IDX_W+1:0] r_steps;
`endif

  logic             w_wr_en;
  logic             w_len_bad;
  logic             w_origin;
  logic [1:0]       w_rd_code;
  logic [IDX_W-1:0] w_t_last;
  logic [IDX_W-1:0] w_r_last;

  function automatic logic [AW-1:0] cell_addr(input logic [IDX_W-1:0] t,
                                               input logic [IDX_W-1:0] r);
    return AW'(t) * AW'(MAX_LEN) + AW'(r);
  endfunction

  assign w_wr_en   = bus.wr_valid && !r_busy;
  assign w_len_bad = (i_t_len == {(IDX_W + 1){1'b0}}) || (i_t_len > LEN_MAX) ||
                     (i_r_len == {(IDX_W + 1){1'b0}}) || (i_r_len > LEN_MAX);
  // A length of MAX_LEN wraps to zero in the low bits, so the subtraction still lands on MAX_LEN-1.
  assign w_t_last  = i_t_len[IDX_W-1:0] - IDX_ONE;
  assign w_r_last  = i_r_len[IDX_W-1:0] - IDX_ONE;
  assign w_origin  = (r_cur_t == IDX_ZERO) && (r_cur_r == IDX_ZERO);
  assign w_rd_code = r_mem[cell_addr(r_cur_t, r_cur_r)];

  assign bus.wr_ready = !r_busy;
  assign bus.o_valid  = r_o_valid;
  assign bus.o_t      = r_o_t;
  assign bus.o_r      = r_o_r;
  assign bus.o_dir    = r_o_dir;
  assign bus.o_last   = r_o_last;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
`ifdef DTW_TB_STEPCNT_EN
  assign o_steps      = r_steps;
`endif

  // Path memory write port; later PE slices overwrite earlier ones on the same cell.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int p = 0; p < N_PE; p++) begin
        if (bus.wr_mask[N_PE-1-p]) begin
          r_mem[cell_addr(bus.wr_tindex[(N_PE-1-p)*IDX_W +: IDX_W],
                          bus.wr_rindex[(N_PE-1-p)*IDX_W +: IDX_W])]
            <= bus.wr_path[(N_PE-1-p)*2 +: 2];
        end
      end
    end
  end

  // Traceback controller and registered step outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cur_t   <= IDX_ZERO;
      r_cur_r   <= IDX_ZERO;
      r_o_t     <= IDX_ZERO;
      r_o_r     <= IDX_ZERO;
      r_o_dir   <= 2'b00;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
`ifdef DTW_TB_STEPCNT_EN
      r_steps   <= {(IDX_W + 2){1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
`ifdef DTW_TB_STEPCNT_EN
            r_steps <= {(IDX_W + 2){1'b0}};
`endif
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_cur_t <= w_t_last;
              r_cur_r <= w_r_last;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_o_t     <= r_cur_t;
          r_o_r     <= r_cur_r;
          r_o_last  <= w_origin;
          r_o_valid <= 1'b1;
          r_state   <= S_EMIT;
          // Edge cells can only move along the edge, whatever was stored.
          if (w_origin) begin
            r_o_dir <= w_rd_code;
          end else if (r_cur_t == IDX_ZERO) begin
            r_o_dir <= 2'b10;
          end else if (r_cur_r == IDX_ZERO) begin
            r_o_dir <= 2'b01;
          end else begin
            r_o_dir <= w_rd_code;
            if (w_rd_code == 2'b11) begin
              r_err <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (bus.o_ready) begin
            r_o_valid <= 1'b0;
`ifdef DTW_TB_STEPCNT_EN
            r_steps   <= r_steps + {{(IDX_W + 1){1'b0}}, 1'b1};
`endif
            if (r_o_last) begin
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_READ;
              case (r_o_dir)
                2'b01:   r_cur_t <= r_cur_t - IDX_ONE;
                2'b10:   r_cur_r <= r_cur_r - IDX_ONE;
                default: begin
                  r_cur_t <= r_cur_t - IDX_ONE;
                  r_cur_r <= r_cur_r - IDX_ONE;
                end
              endcase
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_traceback.sv
// Randomized bench for dtw_traceback against a grid model of the path memory
// and an expected-step list derived from the walk rules.
module tb_dtw_traceback;
  localparam int N_PE    = 6;
  localparam int IDX_W   = 5;
  localparam int MAX_LEN = 32;

  typedef struct {
    int t;
    int r;
    int dir;
    int last;
    int err;
  } step_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W:0]   t_len;
  logic [IDX_W:0]   r_len;
  logic             busy;
  logic             err;
`ifdef DTW_TB_STEPCNT_EN
  logic [IDX_W+1:0] steps;
`endif

  dtw_traceback_if #(.N_PE(N_PE), .IDX_W(IDX_W)) bus ();

  dtw_traceback #(.N_PE(N_PE), .IDX_W(IDX_W), .MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .i_start (start),
    .i_t_len (t_len),
    .i_r_len (r_len),
    .o_busy  (busy),
    .o_err   (err)
`ifdef DTW_TB_STEPCNT_EN
    ,
    .o_steps (steps)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    model [MAX_LEN][MAX_LEN];
  int    want  [MAX_LEN][MAX_LEN];
  step_t exp_q [$];
  int    g_ts [N_PE];
  int    g_rs [N_PE];
  int    g_ps [N_PE];
  logic [N_PE-1:0] g_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One array beat; the model applies enabled slices in PE order so the highest PE wins.
  task automatic write_beat(input logic [N_PE-1:0] mask, input int ts[N_PE], input int rs[N_PE],
                            input int ps[N_PE], input bit accept);
    bus.wr_valid = 1'b1;
    bus.wr_mask  = mask;
    for (int p = 0; p < N_PE; p++) begin
      bus.wr_tindex[(N_PE-1-p)*IDX_W +: IDX_W] = IDX_W'(ts[p]);
      bus.wr_rindex[(N_PE-1-p)*IDX_W +: IDX_W] = IDX_W'(rs[p]);
      bus.wr_path[(N_PE-1-p)*2 +: 2]           = 2'(ps[p]);
    end
    check_val("wr_ready", 32'(bus.wr_ready), 32'(accept));
    tick();
    bus.wr_valid = 1'b0;
    if (accept) begin
      for (int p = 0; p < N_PE; p++) begin
        if (mask[N_PE-1-p]) model[ts[p]][rs[p]] = ps[p];
      end
    end
  endtask

  task automatic fill_region(input int tl, input int rl);
    int ts[N_PE];
    int rs[N_PE];
    int ps[N_PE];
    logic [N_PE-1:0] mask;
    int p;
    int q;
    for (int t = 0; t < tl; t++) begin
      for (int r = 0; r < rl; r++) begin
        mask = '0;
        for (int k = 0; k < N_PE; k++) begin
          ts[k] = int'($urandom_range(0, MAX_LEN - 1));
          rs[k] = int'($urandom_range(0, MAX_LEN - 1));
          ps[k] = int'($urandom_range(0, 3));
        end
        p = int'($urandom_range(1, N_PE - 1));
        ts[p] = t; rs[p] = r; ps[p] = want[t][r];
        mask[N_PE-1-p] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          q = int'($urandom_range(0, p - 1));
          ts[q] = t; rs[q] = r; ps[q] = 3 - want[t][r];
          mask[N_PE-1-q] = 1'b1;
        end
        write_beat(mask, ts, rs, ps, 1'b1);
      end
    end
  endtask

  task automatic build_expected(input int tl, input int rl);
    step_t s;
    int t = tl - 1;
    int r = rl - 1;
    int e = 0;
    exp_q.delete();
    while (1) begin
      s.t = t; s.r = r; s.last = 0;
      if (t == 0 && r == 0) begin
        s.dir = model[t][r]; s.last = 1;
      end else if (t == 0) begin
        s.dir = 2;
      end else if (r == 0) begin
        s.dir = 1;
      end else begin
        s.dir = model[t][r];
        if (s.dir == 3) e = 1;
      end
      s.err = e;
      exp_q.push_back(s);
      if (s.last == 1) break;
      if (s.dir == 1) t--;
      else if (s.dir == 2) r--;
      else begin t--; r--; end
    end
  endtask

  task automatic run_walk(input int tl, input int rl, input int stall_idx, input int rst_idx,
                          input bit busy_beat);
    int cyc;
    step_t e;
    build_expected(tl, rl);
    bus.o_ready = (stall_idx == 0) ? 1'b0 : 1'b1;
    start = 1'b1; t_len = (IDX_W + 1)'(tl); r_len = (IDX_W + 1)'(rl);
    tick();
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      while (!bus.o_valid && cyc < 10) begin
        tick();
        cyc++;
      end
      if (!bus.o_valid) begin
        check_val("step_timeout", 32'd0, 32'd1);
        bus.o_ready = 1'b1;
        return;
      end
      check_val("latency", 32'(cyc), (i == 0) ? 32'd2 : 32'd1);
      check_val("o_t", 32'(bus.o_t), 32'(e.t));
      check_val("o_r", 32'(bus.o_r), 32'(e.r));
      check_val("o_dir", 32'(bus.o_dir), 32'(e.dir));
      check_val("o_last", 32'(bus.o_last), 32'(e.last));
      check_val("err", 32'(err), 32'(e.err));
      check_val("busy", 32'(busy), 32'd1);
      if (i == rst_idx) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_valid", 32'(bus.o_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        bus.o_ready = 1'b1;
        return;
      end
      if (i == stall_idx) begin
        for (int k = 0; k < 5; k++) begin
          if (k == 0 && busy_beat) write_beat(g_mask, g_ts, g_rs, g_ps, 1'b0);
          else tick();
          check_val("stall_valid", 32'(bus.o_valid), 32'd1);
          check_val("stall_t", 32'(bus.o_t), 32'(e.t));
          check_val("stall_r", 32'(bus.o_r), 32'(e.r));
          check_val("stall_dir", 32'(bus.o_dir), 32'(e.dir));
        end
        bus.o_ready = 1'b1;
      end
      tick();
      cyc = 0;
      if (i + 1 == stall_idx) bus.o_ready = 1'b0;
    end
    check_val("done_busy", 32'(busy), 32'd0);
    check_val("done_valid", 32'(bus.o_valid), 32'd0);
`ifdef DTW_TB_STEPCNT_EN
    check_val("steps", 32'(steps), 32'(exp_q.size()));
`endif
    bus.o_ready = 1'b1;
    tick();
  endtask

  task automatic set_want(input int tl, input int rl, input int code);
    for (int t = 0; t < tl; t++)
      for (int r = 0; r < rl; r++) want[t][r] = code;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; t_len = '0; r_len = '0;
    bus.wr_valid = 1'b0; bus.wr_mask = '0; bus.wr_tindex = '0; bus.wr_rindex = '0;
    bus.wr_path = '0; bus.o_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check_val("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check_val("rst_o_t", 32'(bus.o_t), 32'd0);
    check_val("rst_o_r", 32'(bus.o_r), 32'd0);
    check_val("rst_o_dir", 32'(bus.o_dir), 32'd0);
    check_val("rst_o_last", 32'(bus.o_last), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);

    // All-diagonal 4x4 walk
    set_want(4, 4, 0);
    fill_region(4, 4);
    run_walk(4, 4, -1, -1, 1'b0);

    // 3x5 grid walking along row 2, then down column 0
    set_want(3, 5, 0);
    for (int r = 0; r < 5; r++) want[2][r] = 2;
    want[1][0] = 1; want[2][0] = 1;
    fill_region(3, 5);
    run_walk(3, 5, -1, -1, 1'b0);

    // Illegal code inside the grid
    set_want(3, 3, 0);
    want[1][1] = 3;
    fill_region(3, 3);
    run_walk(3, 3, -1, -1, 1'b0);

    // Bad lengths raise err and leave the walker idle
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      t_len = (k == 0) ? (IDX_W + 1)'(0) : (IDX_W + 1)'(MAX_LEN + 1);
      r_len = (IDX_W + 1)'(3);
      tick();
      start = 1'b0;
      tick();
      check_val("badlen_err", 32'(err), 32'd1);
      check_val("badlen_busy", 32'(busy), 32'd0);
      check_val("badlen_valid", 32'(bus.o_valid), 32'd0);
    end

    // Output stall on the second step
    set_want(4, 4, 0);
    fill_region(4, 4);
    run_walk(4, 4, 1, -1, 1'b0);

    // Masked beat dropped while busy, accepted afterwards
    g_ts = '{2, 1, 2, 3, 0, 1};
    g_rs = '{2, 1, 1, 3, 0, 1};
    g_ps = '{2, 3, 1, 2, 3, 2};
    g_mask = 6'b101000;
    run_walk(4, 4, 0, -1, 1'b1);
    write_beat(g_mask, g_ts, g_rs, g_ps, 1'b1);
    run_walk(4, 4, -1, -1, 1'b0);

    // Reset at the third step, then a fresh full walk
    set_want(4, 4, 0);
    fill_region(4, 4);
    run_walk(4, 4, -1, 2, 1'b0);
    tick();
    run_walk(4, 4, -1, -1, 1'b0);

    // Randomized grids including full-size and single-row/column shapes
    for (int n = 0; n < 6; n++) begin
      int tl;
      int rl;
      case (n)
        0: begin tl = MAX_LEN; rl = MAX_LEN; end
        1: begin tl = 1; rl = int'($urandom_range(1, 8)); end
        2: begin tl = int'($urandom_range(1, 8)); rl = 1; end
        default: begin tl = int'($urandom_range(1, 9)); rl = int'($urandom_range(1, 9)); end
      endcase
      for (int t = 0; t < tl; t++)
        for (int r = 0; r < rl; r++)
          want[t][r] = ((n % 2) == 1 && $urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      fill_region(tl, rl);
      run_walk(tl, rl, (n == 3) ? 2 : -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
